// File: rtl/nonrestoring_divider_module.sv
// rtl/nonrestoring_divider_module.sv - sequential signed non-restoring divider
// Divides operand magnitudes, fixes the remainder, then applies signs.
module nonrestoring_divider_module #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_sig,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done_sig,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero,
    output logic         overflow,
    output logic [W:0]   SQ_r,
    output logic [W-1:0] SQ_q,
    output logic [W-1:0] SQ_d
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ITER,
        S_FIX,
        S_SIGN,
        S_DONE,
        S_CLR
    } state_t;

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          sign_a;
    logic          sign_b;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [W:0]    d_ext;
    logic [W:0]    r_shift;
    logic [W:0]    r_next;
    logic          is_ovf;

    always_comb begin
        mag_a   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
        mag_b   = divisor[W-1] ? (~divisor + 1'b1) : divisor;
        d_ext   = {1'b0, SQ_d};
        r_shift = {SQ_r[W-1:0], SQ_q[W-1]};
        // Sign of the previous partial remainder selects subtract or add.
        r_next  = SQ_r[W] ? (r_shift + d_ext) : (r_shift - d_ext);
        is_ovf  = (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == {W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            count     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            done_sig  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            SQ_r      <= '0;
            SQ_q      <= '0;
            SQ_d      <= '0;
        end else if (start_sig) begin
            case (state)
                S_LOAD: begin
                    SQ_d     <= mag_b;
                    SQ_q     <= mag_a;
                    SQ_r     <= '0;
                    sign_a   <= dividend[W-1];
                    sign_b   <= divisor[W-1];
                    count    <= '0;
                    overflow <= is_ovf;
                    if (divisor == '0) begin
                        div_zero  <= 1'b1;
                        quotient  <= {W{1'b1}};
                        remainder <= dividend;
                        state     <= S_DONE;
                    end else begin
                        div_zero <= 1'b0;
                        state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    SQ_r  <= r_next;
                    SQ_q  <= {SQ_q[W-2:0], ~r_next[W]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (SQ_r[W]) begin
                        SQ_r <= SQ_r + d_ext;
                    end
                    state <= S_SIGN;
                end
                S_SIGN: begin
                    // The overflow quotient is left as the raw 100..0 magnitude.
                    quotient  <= ((sign_a ^ sign_b) && !overflow) ? (~SQ_q + 1'b1) : SQ_q;
                    remainder <= sign_a ? (~SQ_r[W-1:0] + 1'b1) : SQ_r[W-1:0];
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done_sig <= 1'b1;
                    state    <= S_CLR;
                end
                S_CLR: begin
                    done_sig <= 1'b0;
                    state    <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider_module.sv
// tb/tb_nonrestoring_divider_module.sv - scoreboard bench for the signed divider
module tb_nonrestoring_divider_module;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_sig;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       done_sig;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       overflow;
    logic [8:0] SQ_r;
    logic [7:0] SQ_q;
    logic [7:0] SQ_d;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_fail  = 0;

    nonrestoring_divider_module #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_sig (start_sig),
        .dividend  (dividend),
        .divisor   (divisor),
        .done_sig  (done_sig),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow),
        .SQ_r      (SQ_r),
        .SQ_q      (SQ_q),
        .SQ_d      (SQ_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_sig) begin
            if (sb.size() == 0) begin
                check("unexpected done_sig", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " quotient"}, 32'(quotient), 32'(e.q));
                check({e.name, " remainder"}, 32'(remainder), 32'(e.r));
                check({e.name, " div_zero"}, 32'(div_zero), 32'(e.dz));
                check({e.name, " overflow"}, 32'(overflow), 32'(e.ov));
                check({e.name, " done cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issues one operation; optional freeze drops start_sig after frz_at active edges.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r, input logic dz,
                          input logic ov, input int frz_at, input int frz_len);
        int   lat;
        int   active;
        int   frozen;
        exp_t e;
        lat    = dz ? 2 : 12;
        active = 0;
        frozen = 0;
        dividend = a;
        divisor  = b;
        e = '{q, r, dz, ov, cyc + lat + frz_len, name};
        sb.push_back(e);
        while (active < lat + 1) begin
            if (active == frz_at && frozen < frz_len) begin
                start_sig = 1'b0;
                if (frozen == 0 || frozen == frz_len - 1) begin
                    check({name, " frozen SQ_r"}, 32'(SQ_r), 32'h1FA);
                    check({name, " frozen SQ_q"}, 32'(SQ_q), 32'h90);
                end
                frozen++;
            end else begin
                start_sig = 1'b1;
                active++;
            end
            @(negedge clk);
        end
        start_sig = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start_sig = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset done_sig", 32'(done_sig), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset SQ_r", 32'(SQ_r), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("100/7",    8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0, -1, 0);
        run_op("-100/7",   8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0, -1, 0);
        run_op("100/-7",   8'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, -1, 0);
        run_op("3/7",      8'd3,    8'd7,    8'h00, 8'h03, 1'b0, 1'b0, -1, 0);
        run_op("-128/-1",  8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1, -1, 0);
        run_op("-128/1",   8'h80,   8'h01,   8'h80, 8'h00, 1'b0, 1'b0, -1, 0);
        run_op("5/0",      8'd5,    8'd0,    8'hFF, 8'h05, 1'b1, 1'b0, -1, 0);
        run_op("9/3",      8'd9,    8'd3,    8'h03, 8'h00, 1'b0, 1'b0, -1, 0);
        run_op("-7/2",     8'hF9,   8'd2,    8'hFD, 8'hFF, 1'b0, 1'b0, -1, 0);
        run_op("127/-128", 8'd127,  8'h80,   8'h00, 8'h7F, 1'b0, 1'b0, -1, 0);
        run_op("100/7 freeze", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 3, 5);

        // Abort mid-iteration with reset.
        dividend  = 8'd100;
        divisor   = 8'd7;
        start_sig = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort done_sig", 32'(done_sig), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort flags", 32'({div_zero, overflow}), 32'd0);
        check("abort SQ regs", 32'({SQ_r, SQ_q, SQ_d}), 32'd0);
        rst       = 1'b0;
        start_sig = 1'b0;
        @(negedge clk);

        run_op("50/5",     8'd50,   8'd5,    8'h0A, 8'h00, 1'b0, 1'b0, -1, 0);

        repeat (5) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider_module.md
Name: nonrestoring_divider_module

Overview:
- Sequential signed divider; the inverse companion to the team's Booth multiplier. Same start_sig/done_sig handshake, one result per request.
- Computes quotient = dividend / divisor, truncated toward zero. The remainder takes the dividend's sign.
- Uses non-restoring division on operand magnitudes, then a remainder fix-up and a sign-application step.
- Exposes internal registers on SQ_* ports for waveform inspection of the algorithm.

Parameters:
W, 8, operand/result width in bits (two's complement); iteration count equals W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start_sig  input  1  level request; must stay high for the whole operation
dividend  input  W  signed dividend, sampled in S_LOAD
divisor  input  W  signed divisor, sampled in S_LOAD
done_sig  output  1  one-cycle completion pulse
quotient  output  W  signed quotient
remainder  output  W  signed remainder
div_zero  output  1  divisor was zero for the last operation
overflow  output  1  dividend = most-negative and divisor = -1 for the last operation
SQ_r  output  W+1  partial-remainder register (signed)
SQ_q  output  W  quotient shift register (magnitude)
SQ_d  output  W  divisor magnitude register

Behaviour:
- Reset (rst=1 at a clk edge) sets every register to 0:
  - outputs done_sig, quotient, remainder, div_zero, overflow, SQ_r, SQ_q, SQ_d all = 0;
  - state = S_LOAD, iteration count = 0.
  - Reset takes priority over everything, including mid-operation; any in-flight division is abandoned.
- Clock gating by start_sig: all state advances only on edges where start_sig=1.
  - If start_sig=0, every register holds, including mid-operation (freeze, not abort).
- State sequence: S_LOAD -> S_ITER (W edges) -> S_FIX -> S_SIGN -> S_DONE -> S_CLR -> S_LOAD.
- S_LOAD:
  - Latch the divisor magnitude into SQ_d and the dividend magnitude into SQ_q. Magnitudes are W-bit unsigned, so the most-negative value gives 2^(W-1).
  - Latch both sign bits. Set SQ_r=0 and clear div_zero and overflow.
  - If divisor=0: set div_zero=1, quotient = all ones (-1), remainder = dividend, and go to S_DONE.
  - If dividend = 100..0 and divisor = all ones: set overflow=1 and continue normally.
- S_ITER, one iteration per edge:
  - Form {SQ_r,SQ_q} shifted left 1 bit.
  - If the old SQ_r >= 0, subtract SQ_d from the upper part; otherwise add SQ_d.
  - The new quotient LSB = ~sign of the new SQ_r.
  - After W iterations, go to S_FIX.
- S_FIX: if SQ_r < 0, add SQ_d to SQ_r; otherwise hold.
- S_SIGN:
  - quotient = SQ_q, negated if the dividend and divisor signs differ.
  - remainder = SQ_r[W-1:0], negated if the dividend is negative.
  - For the overflow case, quotient wraps to 100..0 (the raw magnitude, not negated).
- S_DONE: done_sig <= 1.
- S_CLR: done_sig <= 0, return to S_LOAD.
- Latency:
  - Normal: with start_sig held high from edge 1 (the S_LOAD edge), done_sig is high from edge W+4 to edge W+5. For W=8, high after edge 12 and low after edge 13.
  - Divide-by-zero: done_sig is high after edge 2 and low after edge 3.
- Back-to-back: if start_sig stays high, a new operation loads on the edge after S_CLR.
- Result persistence: quotient, remainder and flags hold their last values until the next S_SIGN (or S_LOAD for the flags and the divide-by-zero result).
- Width rules:
  - The partial remainder is W+1 bits signed; all add/sub in S_ITER and S_FIX are W+1 bits with SQ_d zero-extended.
  - Negation is two's complement, modulo 2^W.

Test Plan:
- 100 / 7, start_sig held -> done_sig pulses after edge 12 only; quotient=14 (0x0E), remainder=2, flags 0.
- -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2); and 100 / -7 -> quotient=0xF2, remainder=0x02; and 3 / 7 -> quotient=0, remainder=3.
- -128 / -1 -> overflow=1, quotient=0x80, remainder=0; and -128 / 1 -> quotient=0x80, remainder=0, overflow=0.
- 5 / 0 -> div_zero=1, quotient=0xFF, remainder=0x05, done_sig high after edge 2 only; the next operation 9 / 3 clears div_zero and gives quotient=3.
- 100 / 7 with start_sig low for 5 cycles during S_ITER -> SQ_r and SQ_q frozen; done_sig arrives 5 cycles late with the same result.
- rst=1 during S_ITER -> next cycle all outputs 0; a fresh 50 / 5 then gives quotient=10, remainder=0 with normal latency.
